// File: rtl/coef_bank_loader.sv
// Double-buffered coefficient store for the folded FIR filter.
// A host streams NTAPS taps into the shadow bank, which becomes active on a frame boundary.
module coef_bank_loader #(
    parameter int NTAPS = 24,
    parameter int CW    = 10,
    parameter int AW    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 in_valid,
    input  logic signed [CW-1:0] in_data,
    output logic                 in_ready,
    input  logic                 frame_start,
    input  logic        [AW-1:0] cnt,
    output logic signed [CW-1:0] coefficient,
    output logic                 busy,
    output logic                 load_done
);

    localparam int IW = $clog2(NTAPS);
    localparam logic [IW-1:0] LastIdx = IW'(NTAPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitSwap
    } state_e;

    state_e                state;
    logic [IW-1:0]         wr_idx;
    logic                  active_sel;
    logic signed [CW-1:0]  bank [2][NTAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            wr_idx      <= '0;
            active_sel  <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            coefficient <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NTAPS; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            load_done <= 1'b0;

            // Uses the pre-edge active_sel, so the read at the swap edge still sees the old bank.
            if (cnt < AW'(NTAPS)) begin
                coefficient <= bank[active_sel][cnt[IW-1:0]];
            end

            unique case (state)
                StIdle: begin
                    if (load_start) begin
                        state    <= StLoad;
                        wr_idx   <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (load_start) begin
                        wr_idx <= '0;
                    end else if (in_valid && in_ready) begin
                        bank[~active_sel][wr_idx] <= in_data;
                        if (wr_idx == LastIdx) begin
                            state    <= StWaitSwap;
                            wr_idx   <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                StWaitSwap: begin
                    if (load_start) begin
                        state    <= StLoad;
                        wr_idx   <= '0;
                        in_ready <= 1'b1;
                    end else if (frame_start) begin
                        state      <= StIdle;
                        active_sel <= ~active_sel;
                        load_done  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_bank_loader.sv
// Scoreboard bench for coef_bank_loader: reads push expected taps, a monitor pops and compares.
module tb_coef_bank_loader;

    localparam int NTAPS = 24;
    localparam int CW    = 10;
    localparam int AW    = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_start = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [CW-1:0] in_data = '0;
    logic                 in_ready;
    logic                 frame_start = 1'b0;
    logic        [AW-1:0] cnt = '0;
    logic signed [CW-1:0] coefficient;
    logic                 busy;
    logic                 load_done;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    logic rd_req = 1'b0;
    int exp_q[$];

    int seq [NTAPS] = '{-1, -2, 4, 5, -8, -11, 15, 20, -29, -43, 75, 231,
                        231, 75, -43, -29, 20, 15, -11, -8, 5, 4, -2, -1};
    int sevens [NTAPS];
    int zeros [NTAPS];

    coef_bank_loader #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .cnt         (cnt),
        .coefficient (coefficient),
        .busy        (busy),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge that samples a requested read produces one coefficient to compare.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got a read with no expected value");
                end else begin
                    e = exp_q.pop_front();
                    check("coefficient", int'(coefficient), e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (load_done) done_pulses++;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rd(input int c, input int e);
        cnt = AW'(c);
        exp_q.push_back(e);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    task automatic sweep(input int v [NTAPS]);
        for (int i = 0; i < NTAPS; i++) rd(i, v[i]);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("in_ready_after_start", int'(in_ready), 1);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic stream(input int v [NTAPS], input bit bubble);
        for (int i = 0; i < NTAPS; i++) begin
            if (bubble && (i % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = CW'(123);
                step();
            end
            in_valid = 1'b1;
            in_data  = CW'(v[i]);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic swap_and_check();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("load_done_pulse", int'(load_done), 1);
        check("busy_after_swap", int'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < NTAPS; i++) begin
            sevens[i] = 7;
            zeros[i]  = 0;
        end

        // Reset
        repeat (3) step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_load_done", int'(load_done), 0);
        check("rst_coefficient", int'(coefficient), 0);
        rst_n = 1'b1;
        step();
        sweep(zeros);

        // Full load and swap
        start_load();
        stream(seq, 1'b0);
        check("in_ready_after_last", int'(in_ready), 0);
        check("busy_wait_swap", int'(busy), 1);
        frame_start = 1'b1;
        rd(23, 0);
        frame_start = 1'b0;
        check("load_done_pulse", int'(load_done), 1);
        check("busy_after_swap", int'(busy), 0);
        sweep(seq);
        check("load_done_single", int'(load_done), 0);
        check("done_count_1", done_pulses, 1);

        // Bubbled stream
        start_load();
        stream(seq, 1'b1);
        repeat (2) step();
        check("bubble_no_early_swap", int'(load_done), 0);
        check("bubble_busy", int'(busy), 1);
        swap_and_check();
        sweep(seq);

        // Restart after 10 words; the word in the restart cycle is dropped
        start_load();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = CW'(3);
            step();
        end
        load_start = 1'b1;
        in_data    = CW'(99);
        step();
        load_start = 1'b0;
        check("restart_in_ready", int'(in_ready), 1);
        stream(sevens, 1'b0);
        check("restart_busy", int'(busy), 1);
        swap_and_check();
        sweep(sevens);

        // Swap guard: frame_start during LOAD and at the final transfer is ignored
        start_load();
        for (int i = 0; i < NTAPS; i++) begin
            in_valid = 1'b1;
            in_data  = CW'(seq[i]);
            if (i == 5) begin
                frame_start = 1'b1;
                rd(23, 7);
            end else if (i == NTAPS - 1) begin
                frame_start = 1'b1;
                rd(0, 7);
            end else begin
                step();
            end
            frame_start = 1'b0;
        end
        in_valid = 1'b0;
        check("guard_load_done", int'(load_done), 0);
        check("guard_busy", int'(busy), 1);
        rd(12, 7);
        check("guard_load_done_2", int'(load_done), 0);
        frame_start = 1'b1;
        rd(23, 7);
        frame_start = 1'b0;
        check("guard_swap_done", int'(load_done), 1);
        rd(11, 231);
        rd(0, -1);
        check("done_count_4", done_pulses, 4);

        // Out-of-range cnt holds the last value
        rd(11, 231);
        rd(30, 231);
        rd(63, 231);

        // Reset during WAIT_SWAP
        start_load();
        stream(sevens, 1'b0);
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_coefficient", int'(coefficient), 0);
        check("mid_rst_load_done", int'(load_done), 0);
        step();
        rst_n = 1'b1;
        step();
        sweep(zeros);
        check("final_done_count", done_pulses, 4);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coef_bank_loader.md
# coef_bank_loader

Writable, double-buffered coefficient store for the folded FIR filter, replacing a fixed coefficient table that can only be preloaded from a file. A host pushes 24 signed 10-bit taps over a valid/ready stream into a shadow bank. The shadow bank becomes active only on a frame boundary from the folding controller. The filter datapath reads the active bank with the same registered, `cnt`-indexed read it uses today.

## Interface
Parameters:
- NTAPS, 24, number of coefficients per bank
- CW, 10, coefficient width (signed two's complement)
- AW, 6, width of tap index `cnt`

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse: begin (or restart) loading the shadow bank at index 0
- in_valid  in  1  `in_data` holds a valid coefficient
- in_data  in  CW  signed coefficient; taps are written in order b[0] to b[NTAPS-1]
- in_ready  out  1  loader accepts `in_data` this cycle
- frame_start  in  1  pulse from the folding controller, asserted in the cycle where `cnt` = NTAPS-1 (last tap of a frame)
- cnt  in  AW  tap index for the read port
- coefficient  out  CW  registered signed coefficient of the active bank at `cnt`
- busy  out  1  loader is in LOAD or WAIT_SWAP
- load_done  out  1  one-cycle pulse when a swap completes

## Operation
- Storage: two banks of NTAPS×CW registers, plus an `active_sel` bit that selects which bank is active.
- Read port: `coefficient <= active_bank[cnt]` on every edge.
  - If `cnt` >= NTAPS, `coefficient` holds its previous value.
- Handshake: a word transfers on an edge where `in_valid && in_ready`.
  - The transferred word is written to `shadow[wr_idx]`, then `wr_idx` increments.
  - `in_data` is never written while `in_ready` = 0.
- State machine:
  - IDLE: `in_ready`=0, `busy`=0. On `load_start`, go to LOAD with `wr_idx`=0.
  - LOAD: `in_ready`=1, `busy`=1.
    - On a transfer with `wr_idx`=NTAPS-1, go to WAIT_SWAP.
    - On `load_start`, set `wr_idx`=0 and stay in LOAD. Any transfer in that same cycle is discarded. Shadow words already written are simply overwritten later.
  - WAIT_SWAP: `in_ready`=0, `busy`=1.
    - On `frame_start`, toggle `active_sel`, pulse `load_done` in the next cycle, and go to IDLE.
    - On `load_start`, go to LOAD with `wr_idx`=0 and no swap. `load_start` wins if it coincides with `frame_start`.
- In LOAD, `frame_start` has no effect. The active bank never changes mid-load.
- `load_start` in IDLE that coincides with `in_valid`: the word is not accepted, because `in_ready` is still 0 in that cycle.

## Timing
- Reset values:
  - state = IDLE, `wr_idx`=0, `active_sel`=0
  - both banks all-zero
  - `coefficient`=0, `in_ready`=0, `busy`=0, `load_done`=0
- Read latency: 1 cycle, from `cnt` sampled at edge N to `coefficient` valid after edge N.
- Swap: the toggle happens at the edge that samples `frame_start`.
  - The read at that same edge uses the old bank (for `cnt`=NTAPS-1).
  - The read at the next edge (for `cnt`=0) uses the new bank.
  - A new frame therefore never mixes banks.
- `in_ready` is a registered state decode. It rises the cycle after `load_start` is sampled and falls the cycle after the NTAPS-th transfer.
- Minimum load time: NTAPS transfers at one per cycle, i.e. 24 cycles plus 1 cycle of entry.
- `frame_start` sampled in the same edge as the last transfer is ignored, since the state is still LOAD. The swap waits for the next `frame_start`.
- Reset asserted mid-load or during WAIT_SWAP: everything returns to reset values immediately, including clearing both banks. No partial swap is possible.

## Test plan
- Reset check: apply reset, then sweep `cnt` 0..23 -> `coefficient`=0 for all taps; `in_ready`=0; `busy`=0.
- Full load and swap: pulse `load_start`, stream 24 words -1,-2,4,5,-8,-11,15,20,-29,-43,75,231,231,75,-43,-29,20,15,-11,-8,5,4,-2,-1 back-to-back. Assert `frame_start` at `cnt`=23.
  - The read for `cnt`=23 in that cycle returns 0 (old bank).
  - The next frame reads exactly the loaded sequence, e.g. `cnt`=11 -> 231 and `cnt`=0 -> -1.
  - `load_done` pulses once.
- Bubbled stream: toggle `in_valid` 1/0 during the load -> only valid cycles are written, the final contents match the sequence, and there is no swap before `frame_start`.
- Restart: after 10 words, pulse `load_start` with `in_valid`=1 -> that word is dropped and `wr_idx` returns to 0. Then 24 words of value 7, then `frame_start` -> every tap reads 7.
- Swap guard: `frame_start` asserted during LOAD and at the edge of the final transfer -> active bank unchanged and `load_done` stays 0. The next `frame_start` swaps.
- Out-of-range and reset: drive `cnt`=30 -> `coefficient` holds its last value. Assert `rst_n`=0 during WAIT_SWAP -> all outputs return to 0 and the active bank reads 0.
